// File: rtl/pattern_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional build macro used by the controller: MATCH_IRQ_EN.
package pattern_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_FRM_W   = 16;

    // Mask with the low 'len' bits set (len up to 16).
    function automatic logic [15:0] len_mask(input logic [4:0] len);
        logic [15:0] m;
        m = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(len)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// History shift register, fill count and masked compare against the pattern.
// 'hit' reflects the history as it will be after the current shift.
module pattern_matcher
    import pattern_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               bit_in,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [MAX_LEN-1:0] next_hist_s;
    logic [LEN_W-1:0]   next_fill_s;
    logic [15:0]        mask_full_s;
    logic [MAX_LEN-1:0] mask_s;

    // Next history/fill values and the masked comparison after the shift.
    always_comb begin
        next_hist_s = {hist_r[MAX_LEN-2:0], bit_in};
        if (fill_r < len) begin
            next_fill_s = fill_r + LEN_W'(1);
        end else begin
            next_fill_s = fill_r;
        end
        mask_full_s = len_mask(5'(len));
        mask_s      = mask_full_s[MAX_LEN-1:0];
        hit         = shift_en && (next_fill_s >= len) &&
                      (((next_hist_s ^ pattern) & mask_s) == {MAX_LEN{1'b0}});
    end

    // History register: clear has priority so a non-overlap hit restarts cleanly.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (shift_en) begin
            hist_r <= next_hist_s;
            fill_r <= next_fill_s;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Frame controller around pattern_matcher: configuration, bit counting,
// match pulse/count and frame-complete pulse.
// Optional build macro MATCH_IRQ_EN adds a sticky irq output with irq_clr input.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int FRM_W   = DEF_FRM_W
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic [FRM_W-1:0]               cfg_frame_bits,
    input  logic                           bit_valid,
    input  logic                           bit_in,
`ifdef MATCH_IRQ_EN
    input  logic                           irq_clr,
    output logic                           irq,
`endif
    output logic                           busy,
    output logic                           z,
    output logic [CNT_W-1:0]               match_count,
    output logic                           done,
    output logic                           cfg_err
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t             state_r;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [FRM_W-1:0]   frame_bits_r;
    logic [FRM_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   match_count_r;
    logic               busy_r;
    logic               z_r;
    logic               done_r;
    logic               cfg_err_r;

    logic               cfg_bad_s;
    logic               accept_s;
    logic               last_s;
    logic               hit_s;
    logic               m_clear_s;

    // Configuration legality, bit acceptance and matcher clear control.
    always_comb begin
        cfg_bad_s = (cfg_len < LEN_W'(2)) || (cfg_len > LEN_W'(MAX_LEN)) ||
                    (cfg_frame_bits == {FRM_W{1'b0}});
        accept_s  = (state_r == RUN) && bit_valid;
        last_s    = accept_s && ((bit_cnt_r + FRM_W'(1)) == frame_bits_r);
        m_clear_s = (state_r == LOAD) || (hit_s && !overlap_r);
    end

    pattern_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clock    (clock),
        .rst_n    (rst_n),
        .shift_en (accept_s),
        .clear    (m_clear_s),
        .bit_in   (bit_in),
        .len      (len_r),
        .pattern  (pattern_r),
        .hit      (hit_s)
    );

    // Frame FSM with registered outputs, bit counter and saturating match counter.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            pattern_r     <= {MAX_LEN{1'b0}};
            len_r         <= {LEN_W{1'b0}};
            overlap_r     <= 1'b0;
            frame_bits_r  <= {FRM_W{1'b0}};
            bit_cnt_r     <= {FRM_W{1'b0}};
            match_count_r <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
            z_r           <= 1'b0;
            done_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            z_r    <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad_s) begin
                            cfg_err_r <= 1'b1;
                        end else begin
                            cfg_err_r <= 1'b0;
                            busy_r    <= 1'b1;
                            state_r   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    pattern_r     <= cfg_pattern;
                    len_r         <= cfg_len;
                    overlap_r     <= cfg_overlap;
                    frame_bits_r  <= cfg_frame_bits;
                    bit_cnt_r     <= {FRM_W{1'b0}};
                    match_count_r <= {CNT_W{1'b0}};
                    state_r       <= RUN;
                end
                RUN: begin
                    if (accept_s) begin
                        bit_cnt_r <= bit_cnt_r + FRM_W'(1);
                        if (hit_s) begin
                            z_r <= 1'b1;
                            if (match_count_r != {CNT_W{1'b1}}) begin
                                match_count_r <= match_count_r + CNT_W'(1);
                            end
                        end
                        if (last_s) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef MATCH_IRQ_EN
    logic irq_r;

    // Sticky interrupt: set by a match or done pulse, set wins over clear.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else if (z_r || done_r) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end
    end

    assign irq = irq_r;
`endif

    assign busy        = busy_r;
    assign z           = z_r;
    assign match_count = match_count_r;
    assign done        = done_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl: a reference model pushes the
// expected z/done/busy for each clock and the values are popped after the edge.
module tb_pattern_detect_ctrl;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic [15:0] cfg_frame_bits;
    logic        bit_valid;
    logic        bit_in;
    logic        busy, z, done, cfg_err;
    logic [7:0]  match_count;
    logic        busy_sat, z_sat, done_sat, cfg_err_sat;
    logic [1:0]  match_count_sat;
`ifdef MATCH_IRQ_EN
    logic        irq_clr;
    logic        irq, irq_sat;
    logic        exp_irq;
`endif

    typedef struct packed {
        logic z;
        logic done;
        logic busy;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        cur_z, cur_done;
    logic [31:0] m_hist;
    int          m_fill, m_cnt;

    always #5 clock = ~clock;

    pattern_detect_ctrl dut (
        .clock(clock), .rst_n(rst_n), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_frame_bits(cfg_frame_bits),
        .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef MATCH_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .busy(busy), .z(z), .match_count(match_count), .done(done), .cfg_err(cfg_err)
    );

    pattern_detect_ctrl #(.CNT_W(2)) dut_sat (
        .clock(clock), .rst_n(rst_n), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_frame_bits(cfg_frame_bits),
        .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef MATCH_IRQ_EN
        .irq_clr(irq_clr), .irq(irq_sat),
`endif
        .busy(busy_sat), .z(z_sat), .match_count(match_count_sat), .done(done_sat),
        .cfg_err(cfg_err_sat)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic ez, input logic ed, input logic eb);
        exp_t e;
        e.z = ez; e.done = ed; e.busy = eb;
        sb.push_back(e);
    endtask

    // One clock: apply the edge, then pop and compare the expected outputs.
    task automatic step();
        exp_t e;
`ifdef MATCH_IRQ_EN
        logic set_c;
        set_c = cur_z | cur_done;
`endif
        @(posedge clock);
        #1;
`ifdef MATCH_IRQ_EN
        if (set_c) exp_irq = 1'b1;
        else if (irq_clr) exp_irq = 1'b0;
        check_eq("irq", {31'd0, irq}, {31'd0, exp_irq});
`endif
        check_eq("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("z", {31'd0, z}, {31'd0, e.z});
            check_eq("done", {31'd0, done}, {31'd0, e.done});
            check_eq("busy", {31'd0, busy}, {31'd0, e.busy});
            cur_z    = e.z;
            cur_done = e.done;
        end
    endtask

    task automatic model_bit(input logic b, input logic [15:0] pat, input int len,
                             input logic ov, output logic hit);
        logic [31:0] mask;
        m_hist = {m_hist[30:0], b};
        if (m_fill < len) m_fill++;
        mask = (32'd1 << len) - 32'd1;
        hit  = (m_fill >= len) && (((m_hist ^ {16'd0, pat}) & mask) == 32'd0);
        if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (!ov) begin
                m_hist = 32'd0;
                m_fill = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_z", {31'd0, z}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check_eq("rst_count", {24'd0, match_count}, 32'd0);
        sb.delete();
        cur_z = 1'b0; cur_done = 1'b0;
`ifdef MATCH_IRQ_EN
        exp_irq = 1'b0;
`endif
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // Runs one frame; abort_at > 0 resets the DUT after that many bits.
    task automatic run_frame(input logic [15:0] pat, input int len, input logic ov,
                             input int nbits, input logic [31:0] bits,
                             input int maxgap, input int abort_at);
        logic hit, last;
        int   gap;
        cfg_pattern = pat[7:0]; cfg_len = 4'(len); cfg_overlap = ov;
        cfg_frame_bits = 16'(nbits); start = 1'b1; bit_valid = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1);
        step();
        check_eq("cfg_err_clr", {31'd0, cfg_err}, 32'd0);
        // LOAD cycle: a qualified bit here must be ignored; start stays high
        bit_valid = 1'b1; bit_in = 1'b1;
        push_exp(1'b0, 1'b0, 1'b1);
        step();
        start = 1'b0;
        cfg_pattern = ~pat[7:0]; cfg_len = 4'd1; cfg_overlap = ~ov;
        m_hist = 32'd0; m_fill = 0; m_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            if (abort_at > 0 && i == abort_at) begin
                do_reset();
                return;
            end
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0; bit_in = 1'($urandom);
                push_exp(1'b0, 1'b0, 1'b1);
                step();
            end
            bit_valid = 1'b1; bit_in = bits[nbits-1-i];
            model_bit(bits[nbits-1-i], pat, len, ov, hit);
            last = (i == nbits - 1);
            if (last) start = 1'b1;
            push_exp(hit, last, !last);
            step();
        end
        // DONE cycle: start held high must be ignored
        bit_valid = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        check_eq("frame_count", {24'd0, match_count}, 32'(m_cnt));
    endtask

    task automatic bad_start(input int len, input int frame);
        cfg_len = 4'(len); cfg_frame_bits = 16'(frame); start = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        check_eq("cfg_err_set", {31'd0, cfg_err}, 32'd1);
        push_exp(1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_pattern = 8'd0; cfg_len = 4'd0;
        cfg_overlap = 1'b0; cfg_frame_bits = 16'd0; bit_valid = 1'b0; bit_in = 1'b0;
        cur_z = 1'b0; cur_done = 1'b0;
`ifdef MATCH_IRQ_EN
        irq_clr = 1'b0; exp_irq = 1'b0;
`endif
        do_reset();

        // 1: overlapping 101010 over 10 bits, last bit matches
        run_frame(16'b101010, 6, 1'b1, 10, 32'b1010101010, 0, 0);
        check_eq("s1_count", {24'd0, match_count}, 32'd3);

        // 2: non-overlapping over 12 bits
        run_frame(16'b101010, 6, 1'b0, 12, 32'b101010101010, 0, 0);
        check_eq("s2_count", {24'd0, match_count}, 32'd2);

        // 3: illegal configurations, count from the previous frame untouched
        bad_start(1, 10);
        bad_start(9, 10);
        bad_start(6, 0);
        check_eq("s3_count_hold", {24'd0, match_count}, 32'd2);

        // 4: gaps between bits, legal start clears cfg_err
        run_frame(16'b101010, 6, 1'b1, 10, 32'b1010101010, 3, 0);
        check_eq("s4_count", {24'd0, match_count}, 32'd3);

        // 5a: reset mid-frame after 4 bits, then a normal frame
        run_frame(16'b10, 2, 1'b1, 10, 32'b1010101010, 0, 4);
        repeat (3) begin
            push_exp(1'b0, 1'b0, 1'b0);
            step();
        end
        run_frame(16'b101010, 6, 1'b1, 10, 32'b1010101010, 0, 0);
        check_eq("s5a_count", {24'd0, match_count}, 32'd3);

        // 5b: five matches, narrow counter saturates
        run_frame(16'b10, 2, 1'b1, 10, 32'b1010101010, 0, 0);
        check_eq("s5b_count", {24'd0, match_count}, 32'd5);
        check_eq("s5b_sat", {30'd0, match_count_sat}, 32'd3);

`ifdef MATCH_IRQ_EN
        // 6: irq is sticky, cleared by irq_clr, set wins over a held clear
        check_eq("s6_irq_set", {31'd0, irq}, 32'd1);
        irq_clr = 1'b1;
        push_exp(1'b0, 1'b0, 1'b0);
        step();
        check_eq("s6_irq_clr", {31'd0, irq}, 32'd0);
        run_frame(16'b101010, 6, 1'b1, 10, 32'b1010101010, 0, 0);
        irq_clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
Controller that sequences a bit-serial stream through a programmable pattern matcher. It works on frames:
- configures the pattern, its length and the overlap mode;
- accepts a fixed number of qualified bits per frame;
- raises a single-cycle match pulse on every hit and counts hits;
- signals frame completion.
It sits between the serial input front end and the status/interrupt logic. It generalises the fixed 101010 detector into a reusable, run-time-configured unit.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16).
CNT_W, 8, width of the match counter.
FRM_W, 16, width of the frame bit-count.

Ports:
clock  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a frame. Sampled only in IDLE.
cfg_pattern  input  MAX_LEN  pattern. Bit [len-1] is the oldest bit, bit [0] is the newest.
cfg_len  input  $clog2(MAX_LEN+1)  pattern length. Legal values are 2..MAX_LEN.
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after a match.
cfg_frame_bits  input  FRM_W  number of bits in the frame (must be 1 or more).
bit_valid  input  1  bit_in is qualified this cycle.
bit_in  input  1  serial data.
busy  output  1  high in LOAD and RUN.
z  output  1  match pulse, one cycle wide.
match_count  output  CNT_W  number of matches in the current or last frame.
done  output  1  frame-complete pulse, one cycle wide.
cfg_err  output  1  sticky illegal-configuration flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE;
  - busy=0, z=0, done=0, cfg_err=0, match_count=0;
  - history and bit counter cleared.
- States:
  - IDLE:
    - start=1 with legal cfg_len → LOAD. cfg_err is cleared.
    - start=1 with cfg_len<2, cfg_len>MAX_LEN or cfg_frame_bits=0 → stay in IDLE, cfg_err=1. No other outputs change.
  - LOAD (1 cycle):
    - latch the pattern, length, overlap and frame_bits;
    - clear history, fill count, bit counter and match_count;
    - → RUN.
    - bit_valid is ignored in LOAD.
  - RUN:
    - Each cycle with bit_valid=1: shift bit_in into the history, increment the fill count (saturating at len) and increment the bit counter.
    - A match occurs when fill count ≥ len after the shift and the low len history bits equal the low len pattern bits.
    - On a match, z=1 on the next clock edge (latency 1 cycle from the accepting edge). match_count increments, saturating at all-ones.
    - If cfg_overlap=0, a match clears the history and fill count. The next match needs len fresh bits.
    - When the bit counter reaches frame_bits on an accepting edge → DONE. The match check for that last bit still applies.
    - bit_valid=0: nothing changes.
  - DONE (1 cycle):
    - done=1;
    - match_count holds until the next LOAD;
    - → IDLE.
- start while busy or in DONE: ignored.
- Config inputs are only looked at in LOAD. Changes during RUN have no effect.
- z and done can both be high in the same cycle only if the last bit of the frame matches. In that cycle z and done are both 1.
- Reset during RUN: the frame is aborted immediately, no done pulse, all outputs return to reset values.
- All outputs are registered.

Optional Feature:
MATCH_IRQ_EN:
- When defined, two extra ports are added: irq output (1 bit) and irq_clr input (1 bit).
- irq is set on any match pulse or done pulse and stays set until irq_clr=1.
- If set and clear happen in the same cycle, set wins.
- irq resets to 0.
- When the macro is undefined, the ports and logic do not exist and the other behaviour is identical.

Decomposition:
- Package pattern_detect_pkg:
  - state enum {IDLE, LOAD, RUN, DONE};
  - default constants for MAX_LEN, CNT_W and FRM_W;
  - function computing the len mask.
- Sub-module pattern_matcher:
  - holds the history shift register, fill count and masked compare;
  - inputs: shift enable, clear, len, pattern;
  - output: combinational hit.
- The controller owns the FSM, bit counter, match counter and outputs.

Test Plan:
1. Overlapping 101010: pattern=6'b101010, len=6, overlap=1, frame=10, bits 1010101010 → z at bits 6, 8 and 10, match_count=3, done once after bit 10.
2. Non-overlapping: same pattern and stream with overlap=0 → one match at bit 6 and one at bit 12 of a 12-bit frame (bits 101010101010), match_count=2.
3. Illegal configuration: start with cfg_len=1 → cfg_err=1, state stays IDLE, busy=0. A later legal start clears cfg_err.
4. Gaps and last bit: same configuration as scenario 1 with bit_valid gaps of 0-3 cycles between bits → the same match positions, z exactly 1 cycle after each accepting edge. If the last bit matches, z and done are both 1 in the same cycle.
5. Reset and saturation:
   - rst_n asserted mid-RUN after 4 bits → all outputs 0, no done pulse, and a new frame works normally.
   - CNT_W=2 with 5 matches → match_count saturates at 3.
6. MATCH_IRQ_EN: irq sets on the first z and stays set. irq_clr clears it. irq_clr asserted in the same cycle as a z → irq stays 1.
